// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Controller FSM; encoding 3 is never produced by the next-state logic.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Bit positions inside the NZCV status word.
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Event counter width and its saturation value.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register-number equality gated by the producer's enable.
  function automatic logic reg_hit(input logic [3:0] src, input logic [3:0] dst,
                                   input logic en);
    return en && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: one cycle from inc_i/clr_i to cnt_o.
// Backpressure: none; sticks at all-ones instead of wrapping.
module hazard_sat_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear first, then increment unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze/flush decode, NZCV flag register, stall/flush counters.
// Latency: freeze/flush combinational; state, status and counters one cycle.
// Backpressure: freeze holds PC and IF/ID; HAZARD_FORWARD_EN narrows stalls to load-use only.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [3:0]       id_src1_i,
  input  logic [3:0]       id_src2_i,
  input  logic             id_two_src_i,
  input  logic [3:0]       ex_dest_i,
  input  logic             ex_wb_en_i,
  input  logic             ex_mem_read_i,
  input  logic [3:0]       mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             ex_branch_i,
  input  logic             ex_s_i,
  input  logic [3:0]       alu_status_i,
  input  logic             cnt_clr_i,
  output logic             freeze_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [3:0]       status_o,
  output logic             carry_bit_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic   src1_hit;
  logic   src2_hit;
  logic   hazard;
  state_t state_q;
  logic [3:0] status_q;

`ifdef HAZARD_FORWARD_EN
  // With forwarding only a load in EX cannot be bypassed in time.
  assign src1_hit = reg_hit(id_src1_i, ex_dest_i, ex_mem_read_i);
  assign src2_hit = reg_hit(id_src2_i, ex_dest_i, ex_mem_read_i);
  logic unused_ok;
  assign unused_ok = ^{ex_wb_en_i, mem_dest_i, mem_wb_en_i};
`else
  // Without forwarding any pending writeback in EX or MEM is a RAW hazard.
  assign src1_hit = reg_hit(id_src1_i, ex_dest_i, ex_wb_en_i) ||
                    reg_hit(id_src1_i, mem_dest_i, mem_wb_en_i);
  assign src2_hit = reg_hit(id_src2_i, ex_dest_i, ex_wb_en_i) ||
                    reg_hit(id_src2_i, mem_dest_i, mem_wb_en_i);
  logic unused_ok;
  assign unused_ok = ex_mem_read_i;
`endif

  assign hazard = id_valid_i && (src1_hit || (id_two_src_i && src2_hit));

  // Pipeline control: a taken branch squashes everything, otherwise a hazard inserts a bubble.
  always_comb begin
    freeze_o      = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (ex_branch_i) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (hazard) begin
      freeze_o      = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  // FSM tracks the last cycle's action; flags load whenever EX sets them, branch or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      status_q <= '0;
    end else begin
      if (ex_s_i) begin
        status_q <= alu_status_i;
      end
      if (ex_branch_i) begin
        state_q <= FLUSH;
      end else if (hazard) begin
        state_q <= STALL;
      end else begin
        state_q <= RUN;
      end
    end
  end

  assign state_o     = state_q;
  assign status_o    = status_q;
  assign carry_bit_o = status_q[C_BIT];

  hazard_sat_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (freeze_o),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_cnt u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ex_branch_i),
    .clr_i (cnt_clr_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a rule-level reference model.
// Latency: checks combinational outputs before the edge, registered outputs 1 time unit after it.
// Backpressure: n/a.
module tb_hazard_ctrl;

  logic        clk, rst;
  logic        id_valid, id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
  logic        ex_branch, ex_s, cnt_clr;
  logic [3:0]  id_src1, id_src2, ex_dest, mem_dest, alu_status;
  logic        freeze, flush_if_id, flush_id_ex, carry_bit;
  logic [3:0]  status;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int total, bad;
  int m_state, m_status, m_stall, m_flush;

  hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid_i    (id_valid),
    .id_src1_i     (id_src1),
    .id_src2_i     (id_src2),
    .id_two_src_i  (id_two_src),
    .ex_dest_i     (ex_dest),
    .ex_wb_en_i    (ex_wb_en),
    .ex_mem_read_i (ex_mem_read),
    .mem_dest_i    (mem_dest),
    .mem_wb_en_i   (mem_wb_en),
    .ex_branch_i   (ex_branch),
    .ex_s_i        (ex_s),
    .alu_status_i  (alu_status),
    .cnt_clr_i     (cnt_clr),
    .freeze_o      (freeze),
    .flush_if_id_o (flush_if_id),
    .flush_id_ex_o (flush_id_ex),
    .status_o      (status),
    .carry_bit_o   (carry_bit),
    .state_o       (state),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules, evaluated on the current inputs.
  function automatic bit m_hit(input int src);
`ifdef HAZARD_FORWARD_EN
    return ex_mem_read && (src == int'(ex_dest));
`else
    return (ex_wb_en && src == int'(ex_dest)) || (mem_wb_en && src == int'(mem_dest));
`endif
  endfunction

  function automatic bit m_hazard();
    return id_valid && (m_hit(int'(id_src1)) || (id_two_src && m_hit(int'(id_src2))));
  endfunction

  function automatic bit m_freeze();
    return !ex_branch && m_hazard();
  endfunction

  function automatic bit m_flush_id_ex();
    return ex_branch || m_hazard();
  endfunction

  task automatic idle();
    id_valid = 0; id_two_src = 0; ex_wb_en = 0; ex_mem_read = 0; mem_wb_en = 0;
    ex_branch = 0; ex_s = 0; cnt_clr = 0;
    id_src1 = 0; id_src2 = 0; ex_dest = 0; mem_dest = 0; alu_status = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_status = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock edge with the model advanced from the inputs present before it.
  task automatic tick();
    int ns, nst, nsc, nfc;
    bit hz;
    hz  = m_hazard();
    ns  = ex_branch ? 2 : (hz ? 1 : 0);
    nst = ex_s ? int'(alu_status) : m_status;
    nsc = m_stall;
    nfc = m_flush;
    if (cnt_clr) begin
      nsc = 0;
      nfc = 0;
    end else begin
      if (!ex_branch && hz && nsc < 65535) nsc++;
      if (ex_branch && nfc < 65535) nfc++;
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_state = ns; m_status = nst; m_stall = nsc; m_flush = nfc;
    end
    #1;
  endtask

  task automatic load_hazard();
    id_valid = 1; id_src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1; ex_mem_read = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #1;
    model_reset();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (status !== 4'd0) begin bad++; $display("FAIL reset_status got=%0h exp=0", status); end
    total++; if (carry_bit !== 1'b0) begin bad++; $display("FAIL reset_carry got=%0b exp=0", carry_bit); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", stall_cnt, flush_cnt); end
    load_hazard();
    #1;
    total++; if (freeze !== m_freeze()) begin
      bad++; $display("FAIL reset_comb_freeze got=%0b exp=%0b", freeze, m_freeze()); end
    idle();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_raw();
    idle();
    id_valid = 1; id_src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1; ex_mem_read = 0;
    #1;
    total++; if (freeze !== m_freeze() || flush_id_ex !== m_flush_id_ex() || flush_if_id !== 1'b0) begin
      bad++; $display("FAIL raw_comb got=%0b%0b%0b exp=%0b%0b0", freeze, flush_id_ex, flush_if_id,
                      m_freeze(), m_flush_id_ex()); end
    tick();
    total++; if (int'(state) !== m_state) begin bad++; $display("FAIL raw_state got=%0d exp=%0d", state, m_state); end
    total++; if (int'(stall_cnt) !== m_stall) begin bad++; $display("FAIL raw_stall got=%0d exp=%0d", stall_cnt, m_stall); end
`ifdef HAZARD_FORWARD_EN
    ex_mem_read = 1;
    #1;
    total++; if (freeze !== m_freeze()) begin
      bad++; $display("FAIL fwd_load_use got=%0b exp=%0b", freeze, m_freeze()); end
    tick();
    total++; if (int'(state) !== m_state) begin bad++; $display("FAIL fwd_state got=%0d exp=%0d", state, m_state); end
`endif
    idle();
    tick();
  endtask

  task automatic test_branch_hazard();
    idle();
    load_hazard();
    ex_branch = 1;
    #1;
    total++; if (freeze !== 1'b0 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      bad++; $display("FAIL br_comb got=%0b%0b%0b exp=011", freeze, flush_if_id, flush_id_ex); end
    tick();
    total++; if (int'(state) !== m_state) begin bad++; $display("FAIL br_state got=%0d exp=%0d", state, m_state); end
    total++; if (int'(flush_cnt) !== m_flush || int'(stall_cnt) !== m_stall) begin
      bad++; $display("FAIL br_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, m_flush, m_stall); end
    idle();
    tick();
  endtask

  task automatic test_flags();
    idle();
    ex_s = 1; alu_status = 4'b0010;
    tick();
    total++; if (int'(status) !== m_status || carry_bit !== 1'b1) begin
      bad++; $display("FAIL flags_load got=%0h/%0b exp=%0h/1", status, carry_bit, m_status); end
    ex_s = 0; alu_status = 4'b1111;
    tick();
    total++; if (int'(status) !== m_status) begin bad++; $display("FAIL flags_hold got=%0h exp=%0h", status, m_status); end
    ex_s = 1; alu_status = 4'b1001; ex_branch = 1;
    tick();
    total++; if (int'(status) !== m_status) begin bad++; $display("FAIL flags_branch got=%0h exp=%0h", status, m_status); end
    idle();
    tick();
  endtask

  task automatic test_random();
    bit exp_f, exp_fi, exp_fe;
    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_two_src  = $urandom_range(0, 1);
      id_src1     = 4'($urandom_range(0, 3));
      id_src2     = 4'($urandom_range(0, 3));
      ex_dest     = 4'($urandom_range(0, 3));
      mem_dest    = 4'($urandom_range(0, 3));
      ex_wb_en    = $urandom_range(0, 1);
      ex_mem_read = $urandom_range(0, 1);
      mem_wb_en   = $urandom_range(0, 1);
      ex_branch   = ($urandom_range(0, 3) == 0);
      ex_s        = $urandom_range(0, 1);
      alu_status  = 4'($urandom);
      cnt_clr     = ($urandom_range(0, 15) == 0);
      #1;
      exp_f = m_freeze(); exp_fi = ex_branch; exp_fe = m_flush_id_ex();
      total++; if (freeze !== exp_f) begin bad++; $display("FAIL rnd_freeze[%0d] got=%0b exp=%0b", i, freeze, exp_f); end
      total++; if (flush_if_id !== exp_fi) begin bad++; $display("FAIL rnd_fif[%0d] got=%0b exp=%0b", i, flush_if_id, exp_fi); end
      total++; if (flush_id_ex !== exp_fe) begin bad++; $display("FAIL rnd_fidex[%0d] got=%0b exp=%0b", i, flush_id_ex, exp_fe); end
      tick();
      total++; if (int'(state) !== m_state) begin bad++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", i, state, m_state); end
      total++; if (int'(status) !== m_status || carry_bit !== status[1]) begin
        bad++; $display("FAIL rnd_status[%0d] got=%0h/%0b exp=%0h", i, status, carry_bit, m_status); end
      total++; if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin
        bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    load_hazard();
    repeat (65535) tick();
    total++; if (int'(stall_cnt) !== m_stall) begin bad++; $display("FAIL sat_preload got=%0d exp=%0d", stall_cnt, m_stall); end
    tick();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
    cnt_clr = 1;
    #1;
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL sat_clr_freeze got=%0b exp=1", freeze); end
    tick();
    total++; if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin
      bad++; $display("FAIL sat_clr got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    ex_s = 1; alu_status = 4'b1010;
    tick();
    ex_s = 0;
    ex_branch = 1;
    tick();
    ex_branch = 0;
    load_hazard();
    tick();
    tick();
    total++; if (int'(state) !== m_state) begin bad++; $display("FAIL mid_pre_state got=%0d exp=%0d", state, m_state); end
    rst = 1;
    #1;
    model_reset();
    total++; if (int'(state) !== m_state || int'(status) !== m_status || carry_bit !== 1'b0) begin
      bad++; $display("FAIL mid_rst_regs got=%0d/%0h/%0b exp=0/0/0", state, status, carry_bit); end
    total++; if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin
      bad++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    total++; if (freeze !== m_freeze()) begin bad++; $display("FAIL mid_rst_comb got=%0b exp=%0b", freeze, m_freeze()); end
    tick();
    rst = 0;
    idle();
    tick();
    total++; if (int'(state) !== m_state || int'(stall_cnt) !== m_stall) begin
      bad++; $display("FAIL mid_resume got=%0d/%0d exp=%0d/%0d", state, stall_cnt, m_state, m_stall); end
    load_hazard();
    tick();
    total++; if (int'(state) !== m_state || int'(stall_cnt) !== m_stall) begin
      bad++; $display("FAIL mid_restall got=%0d/%0d exp=%0d/%0d", state, stall_cnt, m_state, m_stall); end
    idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    idle();
    rst = 1;
    test_reset();
    test_raw();
    test_branch_hazard();
    test_flags();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
